// File: rtl/control_seq.sv
// Clocked control sequencer: owns the IR, cycle counter, carry flag and memory wait handshake.
// Optional memory-wait abort is enabled with the MEM_TIMEOUT_EN macro.
module control_seq #(
  parameter int INST_W  = 8,
  parameter int ALU_W   = 4,
  parameter int RS_W    = 2,
  parameter int CYC_W   = 2,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_valid,
  input  logic [INST_W-1:0] inst,
  output logic              inst_ready,
  input  logic              carry_in,
  input  logic              mem_ready,
  output logic [CYC_W-1:0]  cycle,
  output logic [ALU_W-1:0]  ALU,
  output logic [RS_W-1:0]   RS,
  output logic              WA,
  output logic              WC,
  output logic              RD,
  output logic              WR,
  output logic              J,
  output logic              LJ,
  output logic              ISP,
  output logic              SPD,
  output logic              carry,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, EXEC0, EXEC1, WAIT} state_t;

  localparam logic [CYC_W-1:0] CYC_SAT = {CYC_W{1'b1}};

  state_t             state, state_next;
  logic [INST_W-1:0]  ir;
  logic               carry_q;
  logic [CYC_W-1:0]   cyc_q, cyc_next;
  logic [1:0]         cls;
  logic               sub, flg, take;
  logic               timeout_hit;

  assign cls  = ir[INST_W-1:INST_W-2];
  assign sub  = ir[INST_W-3];
  assign flg  = ir[INST_W-4];
  assign take = ~sub | carry_q;

  // State, instruction register, cycle index and carry flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ir      <= '0;
      carry_q <= 1'b0;
      cyc_q   <= '0;
    end else begin
      state <= state_next;
      cyc_q <= cyc_next;
      if (state == IDLE && inst_valid)
        ir <= inst;
      if (WC)
        carry_q <= carry_in;
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  logic [TMO_W-1:0] tmo_q;

  // Counts WAIT cycles without completion; cleared while the op is being issued
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      tmo_q <= '0;
    else if (state == EXEC0)
      tmo_q <= '0;
    else if (state == WAIT && !mem_ready && !timeout_hit)
      tmo_q <= tmo_q + TMO_W'(1);
  end

  assign timeout_hit = (state == WAIT) && (tmo_q == TMO_W'(TIMEOUT));
  assign err         = timeout_hit;
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  // Next state and strobes; WAIT completion is the only input-dependent strobe
  always_comb begin
    state_next = state;
    WA  = 1'b0;
    WC  = 1'b0;
    RD  = 1'b0;
    WR  = 1'b0;
    J   = 1'b0;
    LJ  = 1'b0;
    ISP = 1'b0;
    case (state)
      IDLE: begin
        if (inst_valid)
          state_next = EXEC0;
      end
      EXEC0: begin
        case (cls)
          2'b00: begin
            WA         = 1'b1;
            WC         = flg;
            state_next = IDLE;
          end
          2'b01: begin
            RD         = ~sub;
            WR         = sub;
            state_next = WAIT;
          end
          2'b10: begin
            if (flg) begin
              LJ         = 1'b1;
              state_next = EXEC1;
            end else begin
              J          = take;
              state_next = IDLE;
            end
          end
          default: begin
            ISP        = 1'b1;
            state_next = IDLE;
          end
        endcase
      end
      EXEC1: begin
        J          = take;
        state_next = IDLE;
      end
      WAIT: begin
        if (timeout_hit) begin
          state_next = IDLE;
        end else begin
          RD = ~sub;
          WR = sub;
          if (mem_ready) begin
            WA         = ~sub;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Cycle index restarts for each instruction and saturates during long waits
  always_comb begin
    if (state_next == IDLE || state_next == EXEC0)
      cyc_next = '0;
    else if (cyc_q == CYC_SAT)
      cyc_next = cyc_q;
    else
      cyc_next = cyc_q + CYC_W'(1);
  end

  assign inst_ready = (state == IDLE);
  assign cycle      = cyc_q;
  assign ALU        = ir[ALU_W-1:0];
  assign RS         = ir[RS_W-1:0];
  assign SPD        = flg;
  assign carry      = carry_q;

endmodule

// File: tb/tb_control_seq.sv
// Directed self-checking bench for control_seq; covers the timeout abort when MEM_TIMEOUT_EN is defined.
module tb_control_seq;

  localparam logic [6:0] S_WA  = 7'b1000000;
  localparam logic [6:0] S_WC  = 7'b0100000;
  localparam logic [6:0] S_RD  = 7'b0010000;
  localparam logic [6:0] S_WR  = 7'b0001000;
  localparam logic [6:0] S_J   = 7'b0000100;
  localparam logic [6:0] S_LJ  = 7'b0000010;
  localparam logic [6:0] S_ISP = 7'b0000001;

  logic       clk = 1'b0;
  logic       rst;
  logic       inst_valid;
  logic [7:0] inst;
  logic       inst_ready;
  logic       carry_in;
  logic       mem_ready;
  logic [1:0] cycle;
  logic [3:0] ALU;
  logic [1:0] RS;
  logic       WA, WC, RD, WR, J, LJ, ISP, SPD, carry, err;
  logic [6:0] strb;

  int testCount = 0;
  int failCount = 0;

  assign strb = {WA, WC, RD, WR, J, LJ, ISP};

  always #5 clk = ~clk;

  control_seq dut (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst(inst),
    .inst_ready(inst_ready), .carry_in(carry_in), .mem_ready(mem_ready),
    .cycle(cycle), .ALU(ALU), .RS(RS), .WA(WA), .WC(WC), .RD(RD), .WR(WR),
    .J(J), .LJ(LJ), .ISP(ISP), .SPD(SPD), .carry(carry), .err(err)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] w, input logic cin, input logic mr);
    inst_valid = v;
    inst       = w;
    carry_in   = cin;
    mem_ready  = mr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a word in IDLE and stop one step into EXEC0 with outputs settled
  task automatic issue(input logic [7:0] w, input logic cin);
    applyStimulus(1'b1, w, cin, 1'b0);
    #1;
    checkOutput("idle_ready", inst_ready, 1);
    checkOutput("idle_strb", strb, 0);
    tick();
    applyStimulus(1'b0, w, cin, 1'b0);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    #2;
    checkOutput("rst_ready", inst_ready, 1);
    checkOutput("rst_strb", strb, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checkOutput("post_rst_strb", {strb, err}, 0);
    checkOutput("post_rst_ready", inst_ready, 1);
    checkOutput("post_rst_carry", carry, 0);
    checkOutput("post_rst_alu_rs", {ALU, RS}, 0);
    checkOutput("post_rst_cycle", cycle, 0);
    tick();

    // ALU op with carry write
    issue(8'b0001_0110, 1'b1);
    checkOutput("alu_strb", strb, S_WA | S_WC);
    checkOutput("alu_field", ALU, 4'b0110);
    checkOutput("alu_rs", RS, 2'b10);
    checkOutput("alu_busy", inst_ready, 0);
    checkOutput("alu_cycle", cycle, 0);
    tick();
    checkOutput("alu_carry", carry, 1);
    checkOutput("alu_done_ready", inst_ready, 1);

    // Clear carry, conditional jump not taken, conditional link jump not taken
    issue(8'b0001_0000, 1'b0);
    checkOutput("clr_strb", strb, S_WA | S_WC);
    tick();
    checkOutput("clr_carry", carry, 0);
    issue(8'b1010_0000, 1'b0);
    checkOutput("jc0_strb", strb, 0);
    tick();
    issue(8'b1011_0000, 1'b0);
    checkOutput("ljc0_e0", strb, S_LJ);
    tick();
    checkOutput("ljc0_e1", strb, 0);
    checkOutput("ljc0_cyc", cycle, 1);
    tick();

    // Set carry, then conditional jump taken straight after
    issue(8'b0001_0000, 1'b1);
    tick();
    checkOutput("set_carry", carry, 1);
    issue(8'b1010_0000, 1'b0);
    checkOutput("jc1_strb", strb, S_J);
    tick();
    issue(8'b1001_0000, 1'b0);
    checkOutput("lj_e0", strb, S_LJ);
    checkOutput("lj_cyc0", cycle, 0);
    tick();
    checkOutput("lj_e1", strb, S_J);
    checkOutput("lj_cyc1", cycle, 1);
    tick();
    checkOutput("lj_idle", strb, 0);

    // Load: mem_ready in EXEC0 ignored, three idle WAIT cycles, then completion
    issue(8'b0100_0001, 1'b0);
    mem_ready = 1'b1;
    #1;
    checkOutput("ld_e0", strb, S_RD);
    checkOutput("ld_cyc0", cycle, 0);
    tick();
    mem_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      if (i == 2) begin
        inst_valid = 1'b1;
        inst       = 8'hFF;
      end
      #1;
      checkOutput("ld_wait", strb, S_RD);
      checkOutput("ld_wcyc", cycle, i);
      checkOutput("ld_alu_hold", ALU, 4'b0001);
      tick();
      inst_valid = 1'b0;
    end
    mem_ready = 1'b1;
    #1;
    checkOutput("ld_done", strb, S_WA | S_RD);
    checkOutput("ld_sat", cycle, 3);
    tick();
    mem_ready = 1'b0;
    #1;
    checkOutput("ld_idle", strb, 0);
    checkOutput("ld_ready", inst_ready, 1);
    checkOutput("ld_carry_kept", carry, 1);

    // Store: long wait
    issue(8'b0110_0000, 1'b0);
    checkOutput("st_e0", strb, S_WR);
    tick();
`ifdef MEM_TIMEOUT_EN
    for (int i = 0; i < 15; i++) begin
      #1;
      checkOutput("st_wait", {strb, err}, {S_WR, 1'b0});
      tick();
    end
    #1;
    checkOutput("st_abort", {strb, err}, {7'b0, 1'b1});
    checkOutput("st_abort_busy", inst_ready, 0);
    tick();
    #1;
    checkOutput("st_after_err", err, 0);
    checkOutput("st_after_ready", inst_ready, 1);
    mem_ready = 1'b1;
    #1;
    checkOutput("st_late_ready", {strb, err}, 0);
    tick();
    mem_ready = 1'b0;
    #1;
    checkOutput("st_late_idle", inst_ready, 1);
`else
    for (int i = 0; i < 20; i++) begin
      #1;
      checkOutput("st_wait", {strb, err}, {S_WR, 1'b0});
      tick();
    end
    mem_ready = 1'b1;
    #1;
    checkOutput("st_done", strb, S_WR);
    tick();
    mem_ready = 1'b0;
    #1;
    checkOutput("st_idle", strb, 0);
    checkOutput("st_ready", inst_ready, 1);
`endif

    // Stack push then pop
    issue(8'b1101_0000, 1'b0);
    checkOutput("push_strb", {strb, SPD}, {S_ISP, 1'b1});
    tick();
    checkOutput("push_idle", strb, 0);
    issue(8'b1100_0000, 1'b0);
    checkOutput("pop_strb", {strb, SPD}, {S_ISP, 1'b0});
    tick();

    // Asynchronous reset in the middle of a load wait
    issue(8'b0100_0000, 1'b0);
    tick();
    #1;
    checkOutput("rw_rd", strb, S_RD);
    #1 rst = 1'b1;
    #1;
    checkOutput("rw_async_strb", strb, 0);
    checkOutput("rw_async_ready", inst_ready, 1);
    checkOutput("rw_async_carry", carry, 0);
    checkOutput("rw_async_cycle", cycle, 0);
    #2 rst = 1'b0;
    tick();
    checkOutput("rw_idle_ready", inst_ready, 1);
    checkOutput("rw_idle_strb", strb, 0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
